sayeh_mem_responder: RTL and testbench

SAYEH_MEM_RESPONDER -- requirements
Module: sayeh_mem_responder

---
 rtl/sayeh_mem_pkg.sv | 14 +
 rtl/sayeh_mem_array.sv | 25 ++
 rtl/sayeh_mem_responder.sv | 134 +++++++++++++
 tb/tb_sayeh_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sayeh_mem_pkg.sv
// Shared types and constants for the SAYEH memory responder.
// Optional out-of-range reporting is enabled with SAYEH_MEM_ERR_EN.
package sayeh_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          WORD_W      = 16;
    localparam logic [15:0] DATABUS_RST = 16'h0000;

endpackage

// File: rtl/sayeh_mem_array.sv
// Word-addressed storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module sayeh_mem_array
    import sayeh_mem_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sayeh_mem_responder.sv
// Wait-state memory responder with a 4-phase ReadMem/WriteMem handshake.
// Define SAYEH_MEM_ERR_EN to flag accesses beyond the implemented depth.
module sayeh_mem_responder
    import sayeh_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       Addressbus,
    input  logic [WORD_W-1:0] Datain,
    input  logic              ReadMem,
    input  logic              WriteMem,
    output logic [WORD_W-1:0] Databus,
    output logic              MemDataReady
`ifdef SAYEH_MEM_ERR_EN
    ,
    output logic              mem_err
`endif
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t            state;
    logic [3:0]        cnt;
    logic [15:0]       addr_q;
    logic [WORD_W-1:0] data_q;
    logic              wr_q;
    logic              err_q;

    logic [15:0]       acc_addr;
    logic [WORD_W-1:0] acc_data;
    logic              acc_wr;
    logic              accept;
    logic              done_next;
    logic              in_range;
    logic              we;
    logic [WORD_W-1:0] rdata;

    assign accept = ReadMem ^ WriteMem;

    // With zero wait states the access finishes on the accepting edge,
    // so the live bus stands in for the not-yet-latched values.
    always_comb begin
        acc_addr  = addr_q;
        acc_data  = data_q;
        acc_wr    = wr_q;
        done_next = 1'b0;
        if (state == IDLE) begin
            acc_addr  = Addressbus;
            acc_data  = Datain;
            acc_wr    = WriteMem;
            done_next = accept && (WS == 4'd0);
        end else if (state == WAIT) begin
            done_next = (cnt <= 4'd1);
        end
    end

`ifdef SAYEH_MEM_ERR_EN
    assign in_range = (16'(acc_addr >> ADDR_BITS) == 16'h0000);
    assign mem_err  = err_q;
`else
    logic unused_bits;
    assign in_range    = 1'b1;
    assign unused_bits = ^{acc_addr, err_q};
`endif

    assign we = rst_n && done_next && acc_wr && in_range;

    sayeh_mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .addr  (acc_addr[ADDR_BITS-1:0]),
        .wdata (acc_data),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            addr_q       <= 16'h0000;
            data_q       <= '0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            Databus      <= DATABUS_RST;
            MemDataReady <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= Addressbus;
                        data_q <= Datain;
                        wr_q   <= WriteMem;
                        if (WS == 4'd0) begin
                            state        <= DONE;
                            MemDataReady <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= WS;
                        end
                    end
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        state        <= DONE;
                        MemDataReady <= 1'b1;
                        cnt          <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (!ReadMem && !WriteMem) begin
                        state        <= IDLE;
                        MemDataReady <= 1'b0;
                        err_q        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (done_next) begin
                err_q <= !in_range;
                if (!acc_wr) begin
                    Databus <= in_range ? rdata : DATABUS_RST;
                end
            end
        end
    end

endmodule

// File: tb/tb_sayeh_mem_responder.sv
// Self-checking bench: vector table, corner sequences, random traffic.
// Expectations come from a word-array model of the memory.
module tb_sayeh_mem_responder;

    localparam int AB = 10;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] Addressbus = 16'h0;
    logic [15:0] Datain = 16'h0;
    logic        ReadMem = 1'b0;
    logic        WriteMem = 1'b0;
    logic [15:0] Databus;
    logic        MemDataReady;
    logic        rd0 = 1'b0;
    logic        wr0 = 1'b0;
    logic [15:0] db0;
    logic        rdy0;
`ifdef SAYEH_MEM_ERR_EN
    logic        mem_err;
    logic        err0;
`endif

    always #5 clk = ~clk;

    sayeh_mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Addressbus   (Addressbus),
        .Datain       (Datain),
        .ReadMem      (ReadMem),
        .WriteMem     (WriteMem),
        .Databus      (Databus),
        .MemDataReady (MemDataReady)
`ifdef SAYEH_MEM_ERR_EN
        ,
        .mem_err      (mem_err)
`endif
    );

    sayeh_mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(0)) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .Addressbus   (Addressbus),
        .Datain       (Datain),
        .ReadMem      (rd0),
        .WriteMem     (wr0),
        .Databus      (db0),
        .MemDataReady (rdy0)
`ifdef SAYEH_MEM_ERR_EN
        ,
        .mem_err      (err0)
`endif
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_db;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [15:0] mem_m [1024];
    logic [9:0]  wq [$];
    logic [15:0] model_db = 16'h0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic inr(input logic [15:0] a);
`ifdef SAYEH_MEM_ERR_EN
        return a < 16'(2**AB);
`else
        return 1'b1;
`endif
    endfunction

    // Reference: updates the model and returns the expected Databus.
    function automatic logic [15:0] model_apply(input logic wr,
                                                input logic [15:0] a,
                                                input logic [15:0] d);
        if (wr) begin
            if (inr(a)) begin
                mem_m[a[9:0]] = d;
                wq.push_back(a[9:0]);
            end
        end else begin
            model_db = inr(a) ? mem_m[a[9:0]] : 16'h0000;
        end
        return model_db;
    endfunction

    task automatic access(input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp_db,
                          input logic mutate, input string name);
        int n;
        logic e_err;
        e_err = !inr(a);
        Addressbus = a;
        Datain = d;
        ReadMem = !wr;
        WriteMem = wr;
        n = 0;
        do begin
            tick();
            n++;
            if (mutate && n == 1) begin
                Addressbus = 16'($urandom);
                Datain = 16'($urandom);
            end
        end while (!MemDataReady && n < 20);
        check({name, " latency"}, n, 1 + WS);
        check({name, " databus"}, Databus, exp_db);
`ifdef SAYEH_MEM_ERR_EN
        check({name, " mem_err"}, mem_err, e_err);
`endif
        tick();
        check({name, " held"}, MemDataReady, 1'b1);
        ReadMem = 1'b0;
        WriteMem = 1'b0;
        Addressbus = 16'($urandom);
        Datain = 16'($urandom);
        tick();
        check({name, " ready drop"}, MemDataReady, 1'b0);
    endtask

    localparam logic [15:0] E400 =
`ifdef SAYEH_MEM_ERR_EN
        16'h0000;
`else
        16'h5A5A;
`endif
    localparam logic [15:0] E7FF =
`ifdef SAYEH_MEM_ERR_EN
        16'h0000;
`else
        16'hFFFF;
`endif

    initial begin
        vec_t tbl [$];
        logic [15:0] e;
        tbl.push_back('{1'b1, 16'h0005, 16'hBEEF, 16'h0000});
        tbl.push_back('{1'b0, 16'h0005, 16'h0000, 16'hBEEF});
        tbl.push_back('{1'b1, 16'h0010, 16'h1234, 16'hBEEF});
        tbl.push_back('{1'b0, 16'h0010, 16'h0000, 16'h1234});
        tbl.push_back('{1'b1, 16'h0000, 16'h5A5A, 16'h1234});
        tbl.push_back('{1'b0, 16'h0400, 16'h0000, E400});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000, 16'h5A5A});
        tbl.push_back('{1'b1, 16'h03FF, 16'hFFFF, 16'h5A5A});
        tbl.push_back('{1'b0, 16'h07FF, 16'h0000, E7FF});
        tbl.push_back('{1'b1, 16'h0003, 16'h3333, E7FF});
        tbl.push_back('{1'b0, 16'h0003, 16'h0000, 16'h3333});

        repeat (3) tick();
        check("reset ready", MemDataReady, 1'b0);
        check("reset databus", Databus, 16'h0000);
`ifdef SAYEH_MEM_ERR_EN
        check("reset mem_err", mem_err, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            e = model_apply(tbl[i].wr, tbl[i].addr, tbl[i].data);
            access(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp_db,
                   1'b0, $sformatf("vec%0d", i));
        end

        // Bus changes after acceptance must not disturb the access.
        access(1'b0, 16'h0005, 16'h0, model_apply(1'b0, 16'h0005, 16'h0),
               1'b1, "addr mutate");
        e = model_apply(1'b1, 16'h0020, 16'h1111);
        access(1'b1, 16'h0020, 16'h1111, e, 1'b1, "data mutate");
        access(1'b0, 16'h0020, 16'h0, model_apply(1'b0, 16'h0020, 16'h0),
               1'b0, "data mutate rd");

        // Both strobes: ignored.
        Addressbus = 16'h0000;
        Datain = 16'hDEAD;
        ReadMem = 1'b1;
        WriteMem = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("both strobes %0d", k), MemDataReady, 1'b0);
        end
        ReadMem = 1'b0;
        WriteMem = 1'b0;
        tick();
        access(1'b0, 16'h0000, 16'h0, model_apply(1'b0, 16'h0000, 16'h0),
               1'b0, "both strobes rd0");

        // Strobe dropped while waiting.
        Addressbus = 16'h0010;
        ReadMem = 1'b1;
        tick();
        ReadMem = 1'b0;
        tick();
        check("drop wait", MemDataReady, 1'b0);
        tick();
        check("drop done", MemDataReady, 1'b1);
        check("drop data", Databus, model_apply(1'b0, 16'h0010, 16'h0));
        tick();
        check("drop exit", MemDataReady, 1'b0);

        // Reset during the wait of a write.
        Addressbus = 16'h0003;
        Datain = 16'hAAAA;
        WriteMem = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        WriteMem = 1'b0;
        #1;
        check("rst wait ready", MemDataReady, 1'b0);
        check("rst wait databus", Databus, 16'h0000);
        model_db = 16'h0000;
        rst_n = 1'b1;
        tick();
        access(1'b0, 16'h0003, 16'h0, model_apply(1'b0, 16'h0003, 16'h0),
               1'b0, "rst wait keep");

        // Zero wait states.
        Addressbus = 16'h0007;
        Datain = 16'h7777;
        wr0 = 1'b1;
        tick();
        check("ws0 wr ready", rdy0, 1'b1);
        check("ws0 wr databus", db0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("ws0 hold %0d", k), rdy0, 1'b1);
        end
        wr0 = 1'b0;
        tick();
        check("ws0 exit", rdy0, 1'b0);
        rd0 = 1'b1;
        tick();
        check("ws0 rd ready", rdy0, 1'b1);
        check("ws0 rd data", db0, 16'h7777);
        rd0 = 1'b0;
        tick();
        check("ws0 rd exit", rdy0, 1'b0);

        // Randomized traffic against the model.
        for (int k = 0; k < 80; k++) begin
            logic        w;
            logic [15:0] a;
            logic [15:0] d;
            logic [9:0]  lo;
            w = (wq.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if (w) begin
                a = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                : {6'b0, 10'($urandom)};
            end else begin
                lo = wq[$urandom_range(0, wq.size() - 1)];
                a = ($urandom_range(0, 3) == 0) ? {6'($urandom), lo}
                                                : {6'b0, lo};
            end
            e = model_apply(w, a, d);
            access(w, a, d, e, 1'($urandom_range(0, 1)),
                   $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
